// File: rtl/jtcop_dma_pkg.sv
// Shared constants for the JTCOP DMA blocks: FSM state encodings and the
// supported range of object-RAM read latency.
package jtcop_dma_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_COPY  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/jtcop_obj_dma_pipe.sv
// Read-latency delay line: carries a valid bit and the word address next to
// each object-RAM read so the write side knows where returned data belongs.
module jtcop_obj_dma_pipe #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [15:0]   rd_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [15:0]   out_data,
  output logic          pending
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [AW-1:0]     addr_q [RD_LAT];
  logic [AW-1:0]     addr_d [RD_LAT];
  logic [15:0]       data_q, data_d;

  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    for (int i = 0; i < RD_LAT; i++) addr_d[i] = '0;
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
    // The address flop counts as the first latency cycle, so the word is
    // sampled as its entry moves into the last stage.
    if (valid_d[RD_LAT-1]) data_d = rd_data;
    if (flush) begin
      valid_d = '0;
      data_d  = '0;
      for (int i = 0; i < RD_LAT; i++) addr_d[i] = '0;
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending = pending | valid_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= addr_d[i];
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];
  assign out_data  = data_q;

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object-RAM DMA: on start, takes the 68000 bus and copies all 2^AW words of
// object RAM into the line-buffer source RAM, then releases the bus.
module jtcop_obj_dma
  import jtcop_dma_pkg::*;
#(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          start,
  input  logic          bg,
  output logic          br,
  output logic          bgack,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  input  logic [15:0]   ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we
);

  // Out-of-range latencies are pulled into the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [2:0]    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          br_q, br_d, bgack_q, bgack_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          pipe_pending;

  // Bus handshake: br is held in REQ until bg is sampled high; bgack then
  // stays high from the first read until the pipeline drains. While bgack is
  // high the CPU cannot retake the bus, so bg is not looked at after grant.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        ram_addr_d = '0;
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bg) begin
          state_d    = ST_COPY;
          ram_addr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_q + CNT_ONE;
        end
      end
      ST_COPY: begin
        // cnt_q[AW] set means address 2^AW-1 is on ram_addr this cycle.
        if (cnt_q[AW]) begin
          state_d = ST_DRAIN;
        end else begin
          ram_addr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: if (!pipe_pending) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    br_d    = (state_d == ST_REQ);
    bgack_d = (state_d == ST_COPY) || (state_d == ST_DRAIN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      br_q       <= 1'b0;
      bgack_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      br_q       <= br_d;
      bgack_q    <= bgack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  jtcop_obj_dma_pipe #(
    .AW     (AW),
    .RD_LAT (LAT)
  ) u_pipe (
    .rst       (rst),
    .clk       (clk),
    .flush     (state_q == ST_IDLE),
    .in_valid  (state_q == ST_COPY),
    .in_addr   (ram_addr_q),
    .rd_data   (ram_dout),
    .out_valid (buf_we),
    .out_addr  (buf_addr),
    .out_data  (buf_din),
    .pending   (pipe_pending)
  );

  assign br       = br_q;
  assign bgack    = bgack_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_addr = ram_addr_q;

endmodule
